// File: rtl/wimax_deinterleaver_pkg.sv
// Shared constants, block type and reference vectors for the WiMax QPSK deinterleaver.
package wimax_deinterleaver_pkg;

  localparam int unsigned NCBPS = 192;
  localparam int unsigned D     = 16;
  localparam int unsigned NCOL  = NCBPS / D;

  typedef logic [NCBPS-1:0] block_t;

  // Applied and compared MSB (index 191) first: bit 191 is j=0 / k=0.
  localparam block_t TV_IN  = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
  localparam block_t TV_OUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

endpackage

// File: rtl/deint_rd_addr_gen.sv
// Read-address walk m_k = 12*(k mod 16) + floor(k/16), built from counters only.
module deint_rd_addr_gen
  import wimax_deinterleaver_pkg::*;
(
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] rd_addr,
  output logic       first,
  output logic       last
);

  localparam logic [3:0] ROW_LAST = 4'(D - 1);
  localparam logic [3:0] COL_LAST = 4'(NCOL - 1);
  localparam logic [7:0] STRIDE   = 8'(NCOL);

  logic [3:0] row;
  logic [3:0] col;

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      row     <= '0;
      col     <= '0;
      rd_addr <= '0;
    end else if (advance) begin
      if (row == ROW_LAST) begin
        row <= '0;
        if (col == COL_LAST) begin
          col     <= '0;
          rd_addr <= '0;
        end else begin
          col     <= col + 4'd1;
          rd_addr <= {4'd0, col + 4'd1};
        end
      end else begin
        row     <= row + 4'd1;
        rd_addr <= rd_addr + STRIDE;
      end
    end
  end

  assign first = (row == 4'd0) && (col == 4'd0);
  assign last  = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/wimax_deinterleaver.sv
// Ping-pong buffered deinterleaver: one bank fills in received order while the other drains
// in original coded order through a single output register.
module wimax_deinterleaver
  import wimax_deinterleaver_pkg::*;
(
  input  logic clk_100mhz,
  input  logic reset,
  input  logic data_in,
  input  logic valid_in,
  output logic ready_out,
  output logic data_out,
  output logic valid_out,
  input  logic ready_in,
  output logic block_start_out
);

  localparam logic [7:0] LAST_ADDR = 8'(NCBPS - 1);

  block_t     bank [2];
  logic [1:0] bank_full;
  logic       wr_sel;
  logic       rd_sel;
  logic [7:0] wr_cnt;
  logic [7:0] rd_addr;
  logic       rd_first;
  logic       rd_last;
  logic       wr_fire;
  logic       rd_load;

  assign ready_out = !reset && !bank_full[wr_sel];
  assign wr_fire   = valid_in && ready_out;
  assign rd_load   = bank_full[rd_sel] && (!valid_out || ready_in);

  deint_rd_addr_gen u_rd_addr_gen (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .advance    (rd_load),
    .rd_addr    (rd_addr),
    .first      (rd_first),
    .last       (rd_last)
  );

  // Bank storage needs no reset; the full flags gate every read.
  always_ff @(posedge clk_100mhz) begin
    if (wr_fire) begin
      bank[wr_sel][wr_cnt] <= data_in;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      bank_full       <= 2'b00;
      wr_sel          <= 1'b0;
      rd_sel          <= 1'b0;
      wr_cnt          <= '0;
      data_out        <= 1'b0;
      valid_out       <= 1'b0;
      block_start_out <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == LAST_ADDR) begin
          wr_cnt            <= '0;
          bank_full[wr_sel] <= 1'b1;
          wr_sel            <= ~wr_sel;
        end else begin
          wr_cnt <= wr_cnt + 8'd1;
        end
      end
      // Write targets an empty bank and read a full one, so these never touch the same flag.
      if (rd_load) begin
        data_out        <= bank[rd_sel][rd_addr];
        valid_out       <= 1'b1;
        block_start_out <= rd_first;
        if (rd_last) begin
          bank_full[rd_sel] <= 1'b0;
          rd_sel            <= ~rd_sel;
        end
      end else if (ready_in) begin
        valid_out       <= 1'b0;
        block_start_out <= 1'b0;
      end
    end
  end

endmodule
